// File: rtl/texture_filter_pkg.sv
// Shared definitions for the texture filter: pixel formats, RGBA channel
// offsets inside a 32-bit RGBA8888 word, and the 16-bit to RGBA8888 expansion.
package texture_filter_pkg;

  localparam logic [1:0] FMT_RGB565   = 2'd0;
  localparam logic [1:0] FMT_RGBA4444 = 2'd1;
  localparam logic [1:0] FMT_RGBA5551 = 2'd2;

  localparam int CH_R = 24;
  localparam int CH_G = 16;
  localparam int CH_B = 8;
  localparam int CH_A = 0;

  // Replicating the top bits spreads the full range onto 0x00..0xFF exactly.
  function automatic logic [31:0] expand_texel(logic [1:0] format, logic [15:0] texel);
    logic [31:0] px;
    px = '0;
    case (format)
      FMT_RGBA4444: begin
        px[CH_R +: 8] = {texel[15:12], texel[15:12]};
        px[CH_G +: 8] = {texel[11:8], texel[11:8]};
        px[CH_B +: 8] = {texel[7:4], texel[7:4]};
        px[CH_A +: 8] = {texel[3:0], texel[3:0]};
      end
      FMT_RGBA5551: begin
        px[CH_R +: 8] = {texel[15:11], texel[15:13]};
        px[CH_G +: 8] = {texel[10:6], texel[10:8]};
        px[CH_B +: 8] = {texel[5:1], texel[5:3]};
        px[CH_A +: 8] = {8{texel[0]}};
      end
      default: begin
        px[CH_R +: 8] = {texel[15:11], texel[15:13]};
        px[CH_G +: 8] = {texel[10:5], texel[10:9]};
        px[CH_B +: 8] = {texel[4:0], texel[4:2]};
        px[CH_A +: 8] = 8'hFF;
      end
    endcase
    return px;
  endfunction

endpackage

// File: rtl/texture_bilinear_filter_if.sv
// Beat interface between the texture buffer, the filter and the fragment stage.
interface texture_bilinear_filter_if #(
  parameter int FRAC_WIDTH = 8,
  parameter int USER_WIDTH = 32
);
  logic                  in_valid;
  logic [USER_WIDTH-1:0] in_user;
  logic [15:0]           texel00;
  logic [15:0]           texel01;
  logic [15:0]           texel10;
  logic [15:0]           texel11;
  logic [FRAC_WIDTH-1:0] frac_s;
  logic [FRAC_WIDTH-1:0] frac_t;
  logic [1:0]            pixel_format;
  logic                  filter_enable;
  logic                  out_valid;
  logic [USER_WIDTH-1:0] out_user;
  logic [31:0]           out_texel;

  modport master (
    output in_valid, in_user, texel00, texel01, texel10, texel11,
           frac_s, frac_t, pixel_format, filter_enable,
    input  out_valid, out_user, out_texel
  );

  modport slave (
    input  in_valid, in_user, texel00, texel01, texel10, texel11,
           frac_s, frac_t, pixel_format, filter_enable,
    output out_valid, out_user, out_texel
  );
endinterface

// File: rtl/lerp_channel.sv
// Combinational 8-bit linear interpolation a + floor((b - a) * f / 2^FRAC_WIDTH).
module lerp_channel #(
  parameter int FRAC_WIDTH = 8
) (
  input  logic [7:0]            a,
  input  logic [7:0]            b,
  input  logic [FRAC_WIDTH-1:0] f,
  output logic [7:0]            res
);
  localparam int PW = FRAC_WIDTH + 10;

  logic signed [8:0]    diff;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] delta;
  logic signed [PW-1:0] sum;

  assign diff  = $signed({1'b0, b}) - $signed({1'b0, a});
  assign prod  = diff * $signed({1'b0, f});
  assign delta = prod >>> FRAC_WIDTH;
  assign sum   = $signed({{(PW-8){1'b0}}, a}) + delta;
  // The blend never leaves [min(a,b), max(a,b)], so dropping the upper bits is exact.
  assign res   = 8'(sum);
endmodule

// File: rtl/texture_bilinear_filter.sv
// Four-stage bilinear texel filter: expand (S1), horizontal lerp (S2),
// vertical lerp (S3), nearest/bilinear select (S4). ce freezes every stage.
module texture_bilinear_filter
  import texture_filter_pkg::*;
#(
  parameter int FRAC_WIDTH = 8,
  parameter int USER_WIDTH = 32
) (
  input  logic aclk,
  input  logic resetn,
  input  logic ce,
  texture_bilinear_filter_if.slave bus
);
  localparam int STAGES = 4;
  localparam int NUM_LANES = 4;

  logic [STAGES:1]                 vldPipe;
  logic [STAGES:1][USER_WIDTH-1:0] userPipe;
  logic [3:1]                      fePipe;

  logic [3:0][31:0]                quadS1;   // 0:e00 1:e01 2:e10 3:e11
  logic [FRAC_WIDTH-1:0]           fracSS1, fracTS1, fracTS2;
  logic [NUM_LANES-1:0][7:0]       topC, botC, vertC;
  logic [NUM_LANES-1:0][7:0]       topS2, botS2, resS3;
  logic [31:0]                     e00S2, e00S3, pixS4;

  // Only the valid chain is reset; reset wins over ce so in-flight beats drop.
  always_ff @(posedge aclk) begin
    if (!resetn) vldPipe <= '0;
    else if (ce) vldPipe <= {vldPipe[STAGES-1:1], bus.in_valid};
  end

  always_ff @(posedge aclk) begin
    if (ce) begin
      quadS1   <= {expand_texel(bus.pixel_format, bus.texel11),
                   expand_texel(bus.pixel_format, bus.texel10),
                   expand_texel(bus.pixel_format, bus.texel01),
                   expand_texel(bus.pixel_format, bus.texel00)};
      fracSS1  <= bus.frac_s;
      fracTS1  <= bus.frac_t;
      topS2    <= topC;
      botS2    <= botC;
      fracTS2  <= fracTS1;
      e00S2    <= quadS1[0];
      resS3    <= vertC;
      e00S3    <= e00S2;
      pixS4    <= fePipe[3] ? resS3 : e00S3;
      userPipe <= {userPipe[STAGES-1:1], bus.in_user};
      fePipe   <= {fePipe[2:1], bus.filter_enable};
    end
  end

  for (genvar ch = 0; ch < NUM_LANES; ch++) begin : gLane
    lerp_channel #(.FRAC_WIDTH(FRAC_WIDTH)) uTop (
      .a(quadS1[0][ch*8 +: 8]), .b(quadS1[1][ch*8 +: 8]), .f(fracSS1), .res(topC[ch]));
    lerp_channel #(.FRAC_WIDTH(FRAC_WIDTH)) uBot (
      .a(quadS1[2][ch*8 +: 8]), .b(quadS1[3][ch*8 +: 8]), .f(fracSS1), .res(botC[ch]));
    lerp_channel #(.FRAC_WIDTH(FRAC_WIDTH)) uVert (
      .a(topS2[ch]), .b(botS2[ch]), .f(fracTS2), .res(vertC[ch]));
  end

  assign bus.out_valid = vldPipe[STAGES];
  assign bus.out_user  = userPipe[STAGES];
  assign bus.out_texel = pixS4;
endmodule

// File: tb/tb_texture_bilinear_filter.sv
// Randomized and directed bench for texture_bilinear_filter against a
// behavioural model of expansion, bilinear blending and 4-cycle latency.
module tb_texture_bilinear_filter;
  logic aclk = 1'b0;
  logic resetn = 1'b0;
  logic ce = 1'b1;
  int total = 0;
  int bad = 0;
  bit started = 1'b0;
  bit lastCe = 1'b0;

  texture_bilinear_filter_if #(.FRAC_WIDTH(8), .USER_WIDTH(32)) bus ();

  texture_bilinear_filter #(.FRAC_WIDTH(8), .USER_WIDTH(32)) dut (
    .aclk(aclk), .resetn(resetn), .ce(ce), .bus(bus));

  always #5 aclk = ~aclk;

  typedef struct {
    bit          v;
    logic [31:0] user;
    logic [31:0] px;
  } ent_t;
  ent_t hist[4];

  function automatic int ex5(int x); return x * 8 + x / 4; endfunction
  function automatic int ex6(int x); return x * 4 + x / 16; endfunction

  // Returns channels as ch[3]=R, ch[2]=G, ch[1]=B, ch[0]=A.
  function automatic void expandRef(int fmt, int t, output int ch[4]);
    if (fmt == 1) begin
      ch[3] = ((t >> 12) & 15) * 17; ch[2] = ((t >> 8) & 15) * 17;
      ch[1] = ((t >> 4) & 15) * 17;  ch[0] = (t & 15) * 17;
    end else if (fmt == 2) begin
      ch[3] = ex5((t >> 11) & 31); ch[2] = ex5((t >> 6) & 31);
      ch[1] = ex5((t >> 1) & 31);  ch[0] = (t & 1) ? 255 : 0;
    end else begin
      ch[3] = ex5((t >> 11) & 31); ch[2] = ex6((t >> 5) & 63);
      ch[1] = ex5(t & 31);         ch[0] = 255;
    end
  endfunction

  function automatic int lerpRef(int a, int b, int f);
    int p;
    p = (b - a) * f;
    // floor division by 256, correct for negative products too
    if (p < 0) return a - ((-p + 255) / 256);
    return a + p / 256;
  endfunction

  function automatic logic [31:0] refPix(int fmt, bit fe, int t00, int t01, int t10,
                                         int t11, int fs, int ft);
    int c00[4], c01[4], c10[4], c11[4];
    int r;
    logic [31:0] px;
    expandRef(fmt, t00, c00); expandRef(fmt, t01, c01);
    expandRef(fmt, t10, c10); expandRef(fmt, t11, c11);
    px = '0;
    for (int k = 0; k < 4; k++) begin
      r = fe ? lerpRef(lerpRef(c00[k], c01[k], fs), lerpRef(c10[k], c11[k], fs), ft) : c00[k];
      px = px | (32'(r & 255) << (8 * k));
    end
    return px;
  endfunction

  // Model: each enabled edge shifts one entry; reset empties the pipe.
  always @(posedge aclk) begin
    lastCe = ce;
    if (!resetn) begin
      for (int i = 0; i < 4; i++) hist[i].v = 1'b0;
    end else if (ce) begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0].v    = bus.in_valid;
      hist[0].user = bus.in_user;
      hist[0].px   = refPix(int'(bus.pixel_format), bus.filter_enable, int'(bus.texel00),
                            int'(bus.texel01), int'(bus.texel10), int'(bus.texel11),
                            int'(bus.frac_s), int'(bus.frac_t));
    end
  end

  always @(negedge aclk) begin
    if (started) begin
      total++;
      if (bus.out_valid !== hist[3].v) begin
        bad++;
        $display("FAIL model_valid t=%0t got=%b want=%b", $time, bus.out_valid, hist[3].v);
      end else if (hist[3].v && (bus.out_texel !== hist[3].px || bus.out_user !== hist[3].user)) begin
        bad++;
        $display("FAIL model_data t=%0t got texel=%h user=%h want texel=%h user=%h",
                 $time, bus.out_texel, bus.out_user, hist[3].px, hist[3].user);
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge aclk);
      bus.in_valid = 1'b0;
      ce = 1'b1;
    end
  endtask

  // One isolated beat; checks it appears exactly 4 cycles later with the literal value.
  task automatic sendOne(string name, int fmt, bit fe, int t00, int t01, int t10, int t11,
                         int fs, int ft, logic [31:0] want);
    @(negedge aclk);
    bus.in_valid = 1'b1; bus.in_user = 32'hA5A5_0000 + 32'(total);
    bus.pixel_format = 2'(fmt); bus.filter_enable = fe;
    bus.texel00 = 16'(t00); bus.texel01 = 16'(t01);
    bus.texel10 = 16'(t10); bus.texel11 = 16'(t11);
    bus.frac_s = 8'(fs); bus.frac_t = 8'(ft);
    @(negedge aclk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge aclk);
    check({name, "_early"}, 32'(bus.out_valid), 32'd0);
    @(negedge aclk);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check(name, bus.out_texel, want);
    idle(2);
  endtask

  initial begin
    int got[$];
    logic [31:0] snapUser, snapTexel;
    int nextBeat;
    bus.in_valid = 1'b0; bus.in_user = '0; bus.pixel_format = '0; bus.filter_enable = 1'b0;
    bus.texel00 = '0; bus.texel01 = '0; bus.texel10 = '0; bus.texel11 = '0;
    bus.frac_s = '0; bus.frac_t = '0;
    for (int i = 0; i < 4; i++) hist[i].v = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    resetn = 1'b1;
    started = 1'b1;
    idle(2);

    sendOne("rgb565_red",  0, 0, 'hF800, 'hF800, 'hF800, 'hF800, 0, 0, 32'hFF0000FF);
    sendOne("rgba4444",    1, 0, 'hF00F, 'h1234, 'h5678, 'h9ABC, 77, 99, 32'hFF0000FF);
    sendOne("rgba5551_a1", 2, 0, 'h0001, 'h0001, 'h0001, 'h0001, 0, 0, 32'h000000FF);
    sendOne("rgba5551_a0", 2, 0, 'hFFFE, 'hFFFE, 'hFFFE, 'hFFFE, 0, 0, 32'hFFFFFF00);
    sendOne("hblend",      0, 1, 'h0000, 'hFFFF, 'h0000, 'hFFFF, 128, 0, 32'h7F7F7FFF);
    sendOne("hblend_neg",  0, 1, 'hFFFF, 'h0000, 'hFFFF, 'h0000, 128, 0, 32'h7F7F7FFF);
    sendOne("vblend",      0, 1, 'h0000, 'h0000, 'hFFFF, 'hFFFF, 0, 64, 32'h3F3F3FFF);
    sendOne("vblend_f0",   0, 1, 'h0000, 'h0000, 'hFFFF, 'hFFFF, 0, 0, 32'h000000FF);
    check("ref_pin", refPix(0, 1, 0, 'hFFFF, 0, 'hFFFF, 255, 0), 32'hFEFEFEFF);

    // Streaming with a 3-cycle stall in the middle.
    nextBeat = 0;
    snapUser = '0; snapTexel = '0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge aclk);
      if (bus.out_valid && lastCe) got.push_back(int'(bus.out_user));
      if (cyc == 5) begin snapUser = bus.out_user; snapTexel = bus.out_texel; end
      if (cyc >= 6 && cyc <= 8) begin
        check("stall_user", bus.out_user, snapUser);
        check("stall_texel", bus.out_texel, snapTexel);
      end
      ce = !(cyc >= 5 && cyc < 8);
      if (ce && nextBeat < 10) begin
        bus.in_valid = 1'b1; bus.in_user = 32'(nextBeat); nextBeat++;
        bus.pixel_format = 2'($urandom_range(0, 3)); bus.filter_enable = 1'b1;
        bus.texel00 = 16'($urandom); bus.texel01 = 16'($urandom);
        bus.texel10 = 16'($urandom); bus.texel11 = 16'($urandom);
        bus.frac_s = 8'($urandom); bus.frac_t = 8'($urandom);
      end else bus.in_valid = 1'b0;
    end
    check("stream_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size() && i < 10; i++) check("stream_order", 32'(got[i]), 32'(i));

    // Reset with 3 beats in flight.
    idle(2);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      bus.in_valid = 1'b1; bus.in_user = 32'(100 + i);
    end
    @(negedge aclk);
    bus.in_valid = 1'b0; resetn = 1'b0;
    @(negedge aclk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("reset_flush", 32'(bus.out_valid), 32'd0);
      @(negedge aclk);
    end
    sendOne("after_reset", 1, 0, 'h0F0F, 0, 0, 0, 0, 0, 32'h00FF00FF);

    // Random traffic; the model process checks every cycle.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge aclk);
      ce = ($urandom_range(0, 7) != 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_user = $urandom;
      bus.pixel_format = 2'($urandom_range(0, 3)); bus.filter_enable = 1'($urandom);
      bus.texel00 = 16'($urandom); bus.texel01 = 16'($urandom);
      bus.texel10 = 16'($urandom); bus.texel11 = 16'($urandom);
      bus.frac_s = 8'($urandom); bus.frac_t = 8'($urandom);
    end
    idle(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/texture_bilinear_filter.md
# texture_bilinear_filter

Pipelined texel filter sitting directly downstream of the texture buffer. Each accepted beat carries the 2x2 texel quad read from the buffer plus the sub-texel fractions. The block expands the 16-bit texels to RGBA8888 and blends them bilinearly, or passes texel00 through when filtering is off. A sideband word travels with each beat so the downstream fragment stage keeps its association. Fixed 4-stage latency, with a global clock-enable for back-pressure.

## Interface
Parameters:
- FRAC_WIDTH, 8, width of the sub-texel fractions; weight = frac / 2^FRAC_WIDTH
- USER_WIDTH, 32, width of the sideband word passed through unchanged

Ports:
- aclk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- ce  in  1  pipeline enable; 0 freezes every stage
- in_valid  in  1  input beat valid
- in_user  in  USER_WIDTH  sideband, delayed with the data
- texel00 / texel01 / texel10 / texel11  in  16 each  quad (row t, t+1; column s, s+1), aligned with in_valid
- frac_s  in  FRAC_WIDTH  horizontal weight toward column s+1
- frac_t  in  FRAC_WIDTH  vertical weight toward row t+1
- pixel_format  in  2  0 RGB565, 1 RGBA4444, 2 RGBA5551, 3 reserved (decoded as RGB565)
- filter_enable  in  1  1 bilinear, 0 nearest (texel00)
- out_valid  out  1  output beat valid
- out_user  out  USER_WIDTH  delayed in_user
- out_texel  out  32  {R[31:24], G[23:16], B[15:8], A[7:0]}

## Operation
- Upstream aligns the frac, format, enable and user fields with the texel outputs of the buffer (the buffer's 1-cycle read delay). This block does not delay them further.
- S1 registers the inputs and expands each texel to RGBA8888:
  - 5-bit channel: {x, x[4:2]}
  - 6-bit channel: {x, x[5:4]}
  - 4-bit channel: {x, x}
  - RGB565: A = 0xFF.
  - RGBA5551: A = 0xFF if bit0 = 1, else 0x00.
  - RGBA4444: bits [15:12] R, [11:8] G, [7:4] B, [3:0] A.
- S2 lerps horizontally per channel:
  - top = lerp(e00, e01, frac_s)
  - bot = lerp(e10, e11, frac_s)
- S3 lerps vertically per channel: res = lerp(top, bot, frac_t).
- S4 output register. If the S1-registered filter_enable is 0, the result is e00 unchanged.
- lerp(a, b, f) = a + ((signed(b − a) * f) >>> FRAC_WIDTH).
  - 9-bit signed difference times unsigned f, arithmetic shift (floor).
  - The result always lies within [min(a,b), max(a,b)], so it is truncated to 8 bits with no saturation.
  - f = 0 yields exactly a. The maximum f does not reach b exactly; this is accepted.
- Each stage carries its own copies of valid, user, frac_t, filter_enable and format.
- Data registers need no reset. Only the valid bits reset.

## Timing
- Latency: 4 enabled cycles from in_valid sampled (ce = 1) to out_valid. Throughput is 1 beat per enabled cycle.
- ce = 0: all stage registers, including the valid bits, hold; outputs are stable. Input is ignored that cycle.
- Beats with in_valid = 0 propagate as bubbles (out_valid = 0). out_texel is don't-care when out_valid = 0.
- Reset values: out_valid = 0 and all internal valid bits = 0. out_texel and out_user are undefined until the first valid beat.
- Reset asserted mid-stream drops all in-flight beats. Reset overrides ce.
- Format or filter_enable changing between consecutive beats takes effect per beat; no flush is needed.

## Structure
- Shared package texture_filter_pkg:
  - pixel-format encodings (RGB565 = 2'd0, RGBA4444 = 2'd1, RGBA5551 = 2'd2)
  - expansion function expand_texel(format, texel) returning 32 bits
  - RGBA channel offsets
- Sub-module lerp_channel: combinational 8-bit lerp, parameterised by FRAC_WIDTH. Instantiated 8× in S2 and 4× in S3.
- Top level holds the pipeline registers and valid/sideband shift chain.

## Test plan
- Expansion: RGB565 quad all 0xF800, filter off → out_texel 0xFF0000FF. RGBA4444 0xF00F → 0xFF0000FF. RGBA5551 0x0001 → 0x000000FF and 0xFFFE → 0xFFFFFF00. Each appears exactly 4 cycles after in_valid.
- Horizontal blend: RGB565, texel00 = texel10 = 0x0000, texel01 = texel11 = 0xFFFF, frac_s = 128, frac_t = 0 → 0x7F7F7FFF. Swapped texels (negative difference) → 0x7F7F7FFF.
- Vertical blend: texel00 = texel01 = 0x0000, texel10 = texel11 = 0xFFFF, frac_s = 0, frac_t = 64 → 0x3F3F3FFF. frac_t = 0 → 0x000000FF.
- Streaming with ce: 10 back-to-back beats with user = 0..9; ce held low 3 cycles mid-stream → outputs freeze during the stall, and all 10 emerge in order with no loss or duplication.
- Reset mid-stream: 3 beats in flight, resetn low 1 cycle → out_valid 0 next cycle and stays 0 until new beats reach 4-cycle latency.
- Random quads/fracs/formats vs. reference model → bit-exact match; out_user matches in_user.
